// File: rtl/rv_decode_pc_unit.sv
// -----------------------------------------------------------------------------
// rv_decode_pc_unit
//
// Fetch-stage program counter register, decode-stage control unit and the
// NOP-insertion mux of a 5-stage RV32I pipeline, grouped in one block.
//
//   - The PC register holds the current fetch address. The +4 adder and the
//     instruction memory live outside; pc_in is the next PC they produce.
//   - The decoder turns the IF/ID instruction into a 21-bit control word.
//   - The mux zeroes the control word for bubbles before it enters ID/EX.
//
// Control word layout (ctrl_raw / ctrl_out):
//   [20:17] ALU_op     [16] load_instr   [15] RF_enable
//   [14:12] S2..S0     [11:9] branchType [8:7] Size
//   [6] E (mem enable) [5] SE            [4] R/W (1 = store)
//   [3] dataMemAddr    [2] AUIPC         [1] JALR     [0] JAL
//
// Ports:
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous, active-high
//   pc_in         in  32   next PC value
//   pc_le         in   1   PC load enable
//   pc_out        out 32   current PC
//   instr         in  32   instruction in ID
//   nop_sel       in   1   1 forces ctrl_out to zero
//   ctrl_raw      out 21   decoder output (combinational)
//   ctrl_out      out 21   muxed control word (combinational)
//   illegal_instr out  1   only with RV_DECODE_ILLEGAL_FLAG_EN defined;
//                          high when the instruction is not decodable
//
// Build option:
//   RV_DECODE_ILLEGAL_FLAG_EN - adds the illegal_instr output.
// -----------------------------------------------------------------------------
module rv_decode_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_le,
  output logic [31:0] pc_out,
  input  logic [31:0] instr,
  input  logic        nop_sel,
  output logic [20:0] ctrl_raw,
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
  output logic [20:0] ctrl_out,
  output logic        illegal_instr
`else
  output logic [20:0] ctrl_out
`endif
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operations
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_APC4  = 4'b1011;

  // Operand-2 select
  localparam logic [2:0] SRC_RS2  = 3'b000;
  localparam logic [2:0] SRC_IIMM = 3'b001;
  localparam logic [2:0] SRC_SIMM = 3'b010;
  localparam logic [2:0] SRC_UIMM = 3'b100;

  // Branch types
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;
  localparam logic [2:0] BR_UNC  = 3'b111;

  // Access sizes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Maps funct3 (plus the funct7[5] qualifier where it matters) to an ALU op.
  // For immediate forms only the shift-right pair looks at funct7[5]; ADDI
  // must not turn into a subtract just because its immediate has bit 10 set.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                input logic       f7b5,
                                                input logic       is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Fetch stage: PC register
  // ---------------------------------------------------------------------------
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (pc_le) begin
      r_pc <= pc_in;
    end
  end

  assign pc_out = r_pc;

  // ---------------------------------------------------------------------------
  // Decode stage: control unit
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_f7b5;

  logic [3:0]  w_alu_op;
  logic        w_load;
  logic        w_rf_en;
  logic [2:0]  w_src2;
  logic [2:0]  w_br_type;
  logic [1:0]  w_size;
  logic        w_mem_en;
  logic        w_sign_ext;
  logic        w_rw;
  logic        w_mem_addr;
  logic        w_auipc;
  logic        w_jalr;
  logic        w_jal;
  logic        w_legal;
  logic [20:0] w_ctrl_fields;
  logic [20:0] w_ctrl_raw;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_f7b5   = instr[30];

  // Register and immediate fields are consumed elsewhere in the pipeline.
  logic w_unused_instr_bits;
  assign w_unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    w_alu_op   = ALU_ADD;
    w_load     = 1'b0;
    w_rf_en    = 1'b0;
    w_src2     = SRC_RS2;
    w_br_type  = BR_NONE;
    w_size     = SZ_BYTE;
    w_mem_en   = 1'b0;
    w_sign_ext = 1'b0;
    w_rw       = 1'b0;
    w_mem_addr = 1'b0;
    w_auipc    = 1'b0;
    w_jalr     = 1'b0;
    w_jal      = 1'b0;
    w_legal    = 1'b0;

    case (w_opcode)
      OP_R: begin
        w_legal  = 1'b1;
        w_alu_op = alu_from_funct(w_funct3, w_f7b5, 1'b1);
        w_rf_en  = 1'b1;
        w_src2   = SRC_RS2;
      end

      OP_I_ALU: begin
        w_legal  = 1'b1;
        w_alu_op = alu_from_funct(w_funct3, w_f7b5, 1'b0);
        w_rf_en  = 1'b1;
        w_src2   = SRC_IIMM;
      end

      OP_LOAD: begin
        w_alu_op   = ALU_ADD;
        w_load     = 1'b1;
        w_rf_en    = 1'b1;
        w_src2     = SRC_IIMM;
        w_mem_en   = 1'b1;
        w_mem_addr = 1'b1;
        case (w_funct3)
          3'b000: begin w_legal = 1'b1; w_size = SZ_BYTE; w_sign_ext = 1'b1; end
          3'b001: begin w_legal = 1'b1; w_size = SZ_HALF; w_sign_ext = 1'b1; end
          3'b010: begin w_legal = 1'b1; w_size = SZ_WORD; w_sign_ext = 1'b1; end
          3'b100: begin w_legal = 1'b1; w_size = SZ_BYTE; w_sign_ext = 1'b0; end
          3'b101: begin w_legal = 1'b1; w_size = SZ_HALF; w_sign_ext = 1'b0; end
          default: w_legal = 1'b0;
        endcase
      end

      OP_STORE: begin
        w_alu_op   = ALU_ADD;
        w_src2     = SRC_SIMM;
        w_mem_en   = 1'b1;
        w_rw       = 1'b1;
        w_mem_addr = 1'b1;
        case (w_funct3)
          3'b000:  begin w_legal = 1'b1; w_size = SZ_BYTE; end
          3'b001:  begin w_legal = 1'b1; w_size = SZ_HALF; end
          3'b010:  begin w_legal = 1'b1; w_size = SZ_WORD; end
          default: w_legal = 1'b0;
        endcase
      end

      OP_BRANCH: begin
        // The ALU subtracts so the branch unit can compare rs1 against rs2.
        w_alu_op = ALU_SUB;
        w_src2   = SRC_RS2;
        case (w_funct3)
          3'b000:  begin w_legal = 1'b1; w_br_type = BR_BEQ;  end
          3'b001:  begin w_legal = 1'b1; w_br_type = BR_BNE;  end
          3'b100:  begin w_legal = 1'b1; w_br_type = BR_BLT;  end
          3'b101:  begin w_legal = 1'b1; w_br_type = BR_BGE;  end
          3'b110:  begin w_legal = 1'b1; w_br_type = BR_BLTU; end
          3'b111:  begin w_legal = 1'b1; w_br_type = BR_BGEU; end
          default: w_legal = 1'b0;
        endcase
      end

      OP_LUI: begin
        w_legal  = 1'b1;
        w_alu_op = ALU_PASSB;
        w_rf_en  = 1'b1;
        w_src2   = SRC_UIMM;
      end

      OP_AUIPC: begin
        w_legal  = 1'b1;
        w_alu_op = ALU_ADD;
        w_rf_en  = 1'b1;
        w_src2   = SRC_UIMM;
        w_auipc  = 1'b1;
      end

      // Jumps write the link address (A+4); the target is computed elsewhere.
      OP_JAL: begin
        w_legal   = 1'b1;
        w_alu_op  = ALU_APC4;
        w_rf_en   = 1'b1;
        w_src2    = SRC_RS2;
        w_br_type = BR_UNC;
        w_jal     = 1'b1;
      end

      OP_JALR: begin
        w_legal   = 1'b1;
        w_alu_op  = ALU_APC4;
        w_rf_en   = 1'b1;
        w_src2    = SRC_RS2;
        w_br_type = BR_UNC;
        w_jalr    = 1'b1;
      end

      default: w_legal = 1'b0;
    endcase
  end

  assign w_ctrl_fields = {w_alu_op, w_load, w_rf_en, w_src2, w_br_type, w_size,
                          w_mem_en, w_sign_ext, w_rw, w_mem_addr,
                          w_auipc, w_jalr, w_jal};

  // Anything undecodable collapses to the all-zero word, which is a bubble.
  assign w_ctrl_raw = w_legal ? w_ctrl_fields : 21'h0;
  assign ctrl_raw   = w_ctrl_raw;

  // ---------------------------------------------------------------------------
  // ID/EX boundary: NOP-insertion mux
  // ---------------------------------------------------------------------------
  // Reset also inserts bubbles so nothing reaches EX before the pipe is live.
  assign ctrl_out = (reset || nop_sel) ? 21'h0 : w_ctrl_raw;

`ifdef RV_DECODE_ILLEGAL_FLAG_EN
  // Reports decode legality only; intentionally independent of nop_sel.
  assign illegal_instr = ~w_legal;
`endif

endmodule

// File: tb/tb_rv_decode_pc_unit.sv
module tb_rv_decode_pc_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_le;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        nop_sel;
  logic [20:0] ctrl_raw;
  logic [20:0] ctrl_out;
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
  logic        illegal_instr;
`endif

  int total;
  int bad;

  rv_decode_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .pc_le    (pc_le),
    .pc_out   (pc_out),
    .instr    (instr),
    .nop_sel  (nop_sel),
    .ctrl_raw (ctrl_raw),
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
    .ctrl_out (ctrl_out),
    .illegal_instr (illegal_instr)
`else
    .ctrl_out (ctrl_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        nop;
    logic [20:0] raw;
    logic [20:0] out;
    logic        ill;
  } vec_t;

  typedef struct {
    int          id;
    logic [20:0] raw;
    logic [20:0] out;
    logic        ill;
  } exp_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;

    //               instr          nop   raw         out         ill
    vecs[0]  = '{32'h00500093, 1'b0, 21'h09000,  21'h09000,  1'b0}; // ADDI
    vecs[1]  = '{32'h402081B3, 1'b0, 21'h28000,  21'h28000,  1'b0}; // SUB
    vecs[2]  = '{32'h00008103, 1'b0, 21'h19068,  21'h19068,  1'b0}; // LB
    vecs[3]  = '{32'h0000C103, 1'b0, 21'h19048,  21'h19048,  1'b0}; // LBU
    vecs[4]  = '{32'h00208023, 1'b0, 21'h02058,  21'h02058,  1'b0}; // SB
    vecs[5]  = '{32'h0020D463, 1'b0, 21'h20800,  21'h20800,  1'b0}; // BGE
    vecs[6]  = '{32'h008000EF, 1'b0, 21'h168E01, 21'h168E01, 1'b0}; // JAL
    vecs[7]  = '{32'h000080E7, 1'b0, 21'h168E02, 21'h168E02, 1'b0}; // JALR
    vecs[8]  = '{32'h00008103, 1'b1, 21'h19068,  21'h00000,  1'b0}; // LB + NOP
    vecs[9]  = '{32'h00008103, 1'b0, 21'h19068,  21'h19068,  1'b0}; // NOP released
    vecs[10] = '{32'hFFFFFFFF, 1'b0, 21'h00000,  21'h00000,  1'b1}; // all ones
    vecs[11] = '{32'h00000000, 1'b0, 21'h00000,  21'h00000,  1'b1}; // zero word
    vecs[12] = '{32'h123450B7, 1'b0, 21'h14C000, 21'h14C000, 1'b0}; // LUI
    vecs[13] = '{32'h00000097, 1'b0, 21'h0C004,  21'h0C004,  1'b0}; // AUIPC
    vecs[14] = '{32'h4020D093, 1'b0, 21'hE9000,  21'hE9000,  1'b0}; // SRAI
    vecs[15] = '{32'h0020A023, 1'b0, 21'h02158,  21'h02158,  1'b0}; // SW
    vecs[16] = '{32'h0000B103, 1'b0, 21'h00000,  21'h00000,  1'b1}; // load f3=011
    vecs[17] = '{32'h0020C1B3, 1'b0, 21'h88000,  21'h88000,  1'b0}; // XOR
    vecs[18] = '{32'h0020A463, 1'b0, 21'h00000,  21'h00000,  1'b1}; // branch f3=010
    vecs[19] = '{32'h0000D103, 1'b0, 21'h190C8,  21'h190C8,  1'b0}; // LHU
    vecs[20] = '{32'h0010B093, 1'b0, 21'h129000, 21'h129000, 1'b0}; // SLTIU
    vecs[21] = '{32'hFFFFFFFF, 1'b1, 21'h00000,  21'h00000,  1'b1}; // illegal + NOP

    // Reset phase: legal instruction present, reset must still hide it.
    reset   = 1'b1;
    pc_le   = 1'b1;
    pc_in   = 32'h4;
    nop_sel = 1'b0;
    instr   = 32'h00500093;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", pc_out, 32'h0);
    check("reset_ctrl_out", {11'h0, ctrl_out}, 32'h0);
    check("reset_ctrl_raw", {11'h0, ctrl_raw}, {11'h0, 21'h09000});

    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pc_load", pc_out, 32'h4);

    pc_le = 1'b0;
    pc_in = 32'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pc_hold", pc_out, 32'h4);

    pc_le = 1'b1;
    pc_in = 32'hFFFF_FFFC;
    @(posedge clk);
    @(negedge clk);
    check("pc_load_top", pc_out, 32'hFFFF_FFFC);

    pc_in = 32'h0000_1000;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pc_reset_wins", pc_out, 32'h0);
    reset = 1'b0;
    pc_le = 1'b0;

    // Decode table: push expectation at drive time, pop once outputs settle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      instr   = vecs[i].instr;
      nop_sel = vecs[i].nop;
      sb.push_back('{i, vecs[i].raw, vecs[i].out, vecs[i].ill});
      #2;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_raw", e.id), {11'h0, ctrl_raw}, {11'h0, e.raw});
        check($sformatf("vec%0d_out", e.id), {11'h0, ctrl_out}, {11'h0, e.out});
`ifdef RV_DECODE_ILLEGAL_FLAG_EN
        check($sformatf("vec%0d_ill", e.id), {31'h0, illegal_instr}, {31'h0, e.ill});
`endif
      end
    end

    check("pc_stable_after_decode", pc_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
